// File: rtl/rr_channel_dispatcher_pkg.sv
// Shared constants and the rotated-mask priority helper for the round-robin dispatcher.
// The per-instance widths are re-derived in each module from its own parameters.
package rr_dispatch_pkg;

    localparam int DEF_NUM_CH = 5;
    localparam int DEF_DEPTH  = 4;
    localparam int PTR_W      = $clog2(DEF_DEPTH);
    localparam int LVL_W      = PTR_W + 1;
    localparam int CH_W       = $clog2(DEF_NUM_CH);
    localparam int MAX_CH     = 32;

    // Offset of the lowest set bit of a mask already rotated so bit 0 is the rr pointer.
    function automatic int first_set(input logic [MAX_CH-1:0] mask);
        int r;
        r = 0;
        for (int j = MAX_CH - 1; j >= 0; j--) begin
            if (mask[j]) begin
                r = j;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_channel_dispatcher_fifo.sv
// Single-clock first-word-fall-through FIFO used as one dispatcher output lane.
// Occupancy carries one extra bit so a full FIFO is distinguishable from an empty one.
module chan_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              w_do_wr;
    logic              w_do_rd;

    assign empty   = (r_level == LW'(0));
    assign full    = (r_level == LW'(DEPTH));
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_do_wr = wr_en & ~full;
    assign w_do_rd = rd_en & ~empty;

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/rr_channel_dispatcher.sv
// Round-robin fan-out of one valid/ready stream into NUM_CH buffered FWFT lanes.
// Selection skips disabled and full lanes; fullness comes from registered occupancy only.
module rr_channel_dispatcher
    import rr_dispatch_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CH-1:0]                    ch_en,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_W-1:0]                    in_data,
    output logic [NUM_CH-1:0]                    out_valid,
    input  logic [NUM_CH-1:0]                    out_ready,
    output logic [NUM_CH*DATA_W-1:0]             out_data,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]  fill_level,
    output logic [CNT_W-1:0]                     dispatch_cnt,
    output logic                                 idle
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IDX_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_wr;
    logic [MAX_CH-1:0] w_rot;
    logic [IDX_W-1:0]  w_sel;
    logic              w_accept;

    assign w_elig   = ch_en & ~w_full;
    assign in_ready = rst_n & (|w_elig);
    assign w_accept = in_valid & in_ready;

    // Rotate eligibility so the pointer sits at bit 0, then map the winner back.
    always_comb begin
        int idx;
        int s;
        w_rot = '0;
        idx   = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            idx = int'(r_ptr) + j;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end else begin
                idx = idx;
            end
            w_rot[j] = w_elig[idx];
        end
        s = int'(r_ptr) + first_set(w_rot);
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end else begin
            s = s;
        end
        w_sel = IDX_W'(s);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        assign w_wr[g] = w_accept & (w_sel == IDX_W'(g));

        chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (w_wr[g]),
            .wr_data (in_data),
            .rd_en   (out_ready[g]),
            .rd_data (out_data[g*DATA_W +: DATA_W]),
            .empty   (w_empty[g]),
            .full    (w_full[g]),
            .level   (fill_level[g*OCC_W +: OCC_W])
        );
    end

    assign out_valid    = ~w_empty;
    assign idle         = &w_empty;
    assign dispatch_cnt = r_cnt;

    // Pointer moves past the lane just served; counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_sel == IDX_W'(NUM_CH - 1)) ? '0 : w_sel + IDX_W'(1);
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rr_channel_dispatcher.sv
// Directed plus randomized bench for rr_channel_dispatcher against a queue-based lane model.
module tb_rr_channel_dispatcher;

    localparam int N  = 5;
    localparam int DW = 16;
    localparam int D  = 4;
    localparam int CW = 4;
    localparam int LW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      ch_en;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready;
    logic [N*DW-1:0]   out_data;
    logic [N*LW-1:0]   fill_level;
    logic [CW-1:0]     dispatch_cnt;
    logic              idle;

    always #5 clk = ~clk;

    rr_channel_dispatcher #(.NUM_CH(N), .DATA_W(DW), .DEPTH(D), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_en        (ch_en),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .fill_level   (fill_level),
        .dispatch_cnt (dispatch_cnt),
        .idle         (idle)
    );

    logic [DW-1:0] q [N][$];
    int m_ptr;
    int m_cnt;
    int n_checks;
    int n_fail;
    int n_acc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec rule: first enabled, non-full lane scanning from the pointer; -1 if none.
    function automatic int m_sel();
        for (int k = 0; k < N; k++) begin
            if (ch_en[(m_ptr + k) % N] && q[(m_ptr + k) % N].size() < D) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        logic [N*DW-1:0] ed, mk;
        logic [N-1:0]    ev;
        logic [N*LW-1:0] ef;
        logic            er;
        int              s;
        #1;
        s  = m_sel();
        er = rst_n && (s >= 0);
        ev = '0; ed = '0; mk = '0; ef = '0;
        for (int i = 0; i < N; i++) begin
            ef[i*LW +: LW] = LW'(q[i].size());
            if (q[i].size() > 0) begin
                ev[i] = 1'b1;
                ed[i*DW +: DW] = q[i][0];
                mk[i*DW +: DW] = '1;
            end
        end
        chk("in_ready",     128'(in_ready),            128'(er));
        chk("out_valid",    128'(out_valid),           128'(ev));
        chk("out_data",     128'(out_data & mk),       128'(ed));
        chk("fill_level",   128'(fill_level),          128'(ef));
        chk("dispatch_cnt", 128'(dispatch_cnt),        128'(m_cnt));
        chk("idle",         128'(idle),                128'(ev == '0));
        if (in_valid && in_ready) n_acc++;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < N; i++) q[i].delete();
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (out_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
            end
            if (in_valid && er) begin
                q[s].push_back(in_data);
                m_ptr = (s + 1) % N;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_acc = 0; m_ptr = 0; m_cnt = 0;
        rst_n = 1'b0; ch_en = 5'h1F; in_valid = 1'b0; in_data = 16'h0000; out_ready = 5'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();

        // Plain rotation through all lanes with consumers ready.
        out_ready = 5'h1F;
        for (int w = 1; w <= 5; w++) begin
            in_valid = 1'b1; in_data = DW'(w);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("t1_cnt", 128'(dispatch_cnt), 128'(5));

        // Lane 2 disabled: it must be skipped.
        ch_en = 5'b11011;
        for (int w = 0; w < 5; w++) begin
            in_valid = 1'b1; in_data = DW'(16'h0100 + w);
            step();
        end
        in_valid = 1'b0;
        step();

        // Back-pressure: exactly N*D words fit.
        ch_en = 5'h1F; out_ready = 5'h00; n_acc = 0;
        for (int w = 0; w < 24; w++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            step();
        end
        chk("t3_accepts", 128'(n_acc), 128'(20));
        chk("t3_all_full", 128'(fill_level), 128'({5{3'd4}}));
        out_ready = 5'b01000;
        step();
        out_ready = 5'b00000; n_acc = 0;
        step();
        step();
        chk("t3_one_more", 128'(n_acc), 128'(1));
        chk("t3_ch3_full", 128'(fill_level[3*LW +: LW]), 128'(4));

        // Same-cycle push and pop on one lane at level 2.
        in_valid = 1'b0; out_ready = 5'h1F;
        repeat (6) step();
        ch_en = 5'b00001; out_ready = 5'h00; in_valid = 1'b1;
        in_data = 16'hA001; step();
        in_data = 16'hA002; step();
        in_data = 16'hA003; out_ready = 5'b00001; step();
        in_valid = 1'b0; out_ready = 5'h00; step();
        chk("t4_level", 128'(fill_level[LW-1:0]), 128'(2));
        chk("t4_head",  128'(out_data[DW-1:0]),   128'(16'hA002));

        // Reset with words buffered, then first word must land on lane 0.
        ch_en = 5'h1F; in_valid = 1'b1;
        for (int w = 0; w < 3; w++) begin
            in_data = DW'($urandom); step();
        end
        rst_n = 1'b0; step();
        rst_n = 1'b1; in_valid = 1'b0; step();
        chk("t6_idle", 128'(idle), 128'(1));
        chk("t6_cnt",  128'(dispatch_cnt), 128'(0));
        in_valid = 1'b1; in_data = 16'h5A5A; step();
        in_valid = 1'b0; step();
        chk("t6_first_lane", 128'(out_valid), 128'(5'b00001));

        // Saturation of the narrow counter.
        out_ready = 5'h1F;
        for (int w = 0; w < 20; w++) begin
            in_valid = 1'b1; in_data = DW'($urandom); step();
        end
        in_valid = 1'b0; step();
        chk("t5_sat", 128'(dispatch_cnt), 128'(15));

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            ch_en     = N'($urandom);
            in_valid  = 1'($urandom);
            in_data   = DW'($urandom);
            out_ready = N'($urandom) & N'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
